// File: rtl/id_stage_sb_if.sv
// id_stage_sb_if: IF->ID instruction handshake and ID->EX decode packet of id_stage_sb.
// master is the surrounding pipeline (IF + EX), slave is the decode stage.
interface id_stage_sb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            valid_i, ack_o, ack_i, valid_o;
    logic [XLEN-1:0] instr_i, pc_i, instr_o, pc_o, rs1_o, rs2_o, imm_o;
    logic [AW-1:0]   rd_o;
    modport master (output valid_i, instr_i, pc_i, ack_i,
                    input  ack_o, valid_o, instr_o, pc_o, rs1_o, rs2_o, imm_o, rd_o);
    modport slave  (input  valid_i, instr_i, pc_i, ack_i,
                    output ack_o, valid_o, instr_o, pc_o, rs1_o, rs2_o, imm_o, rd_o);
endinterface

// File: rtl/id_stage_sb.sv
// id_stage_sb: decode stage with a per-register outstanding-write counter scoreboard.
// Define ID_PERF_EN to add the perf_stall_o / perf_issue_o counters.
module id_stage_sb #(
    parameter int  XLEN   = 32,
    parameter int  NREGS  = 32,
    parameter int  CNT_W  = 2,
    parameter int  NUM_WB = 2,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst_i,
    input  logic                 flush_i,
    id_stage_sb_if.slave         bus,
    output logic [AW-1:0]        rs1a_o,
    output logic [AW-1:0]        rs2a_o,
    input  logic [XLEN-1:0]      rs1d_i,
    input  logic [XLEN-1:0]      rs2d_i,
    input  logic [NUM_WB-1:0]    wb_valid_i,
    input  logic [NUM_WB*AW-1:0] wb_rd_i,
    output logic                 stall_o,
    output logic                 sb_err_o
`ifdef ID_PERF_EN
    ,
    output logic [31:0]          perf_stall_o,
    output logic [31:0]          perf_issue_o
`endif
);
    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67,
                           OP_BR = 7'h63, OP_LOAD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13,
                           OP_OP = 7'h33, OP_SYS = 7'h73;
    logic [31:0]                 ins, imm32;
    logic [6:0]                  op;
    logic [AW-1:0]               rd, rd_q;
    logic                        uses_rs1, uses_rs2, writes_rd, haz1, haz2, sat, can, accept;
    logic                        err_d, err_q, valid_q;
    logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]             instr_q, pc_q, rs1_q, rs2_q, imm_q;

    assign ins       = bus.instr_i[31:0];
    assign op        = ins[6:0];
    assign rd        = ins[7 +: AW];
    assign rs1a_o    = ins[15 +: AW];
    assign rs2a_o    = ins[20 +: AW];
    assign writes_rd = op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_SYS, OP_OP};
    assign uses_rs1  = op inside {OP_JALR, OP_LOAD, OP_IMM, OP_SYS, OP_OP, OP_BR, OP_ST};
    assign uses_rs2  = op inside {OP_OP, OP_BR, OP_ST};
    assign imm32 = (op inside {OP_JALR, OP_LOAD, OP_IMM, OP_SYS}) ? {{20{ins[31]}}, ins[31:20]} :
                   (op == OP_ST) ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                   (op == OP_BR) ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                   (op inside {OP_LUI, OP_AUIPC}) ? {ins[31:12], 12'b0} :
                   (op == OP_JAL) ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} : '0;

    // x0 is excluded from every hazard term; reset suppresses ack/stall
    assign haz1    = uses_rs1 && rs1a_o != '0 && cnt_q[rs1a_o] != '0;
    assign haz2    = uses_rs2 && rs2a_o != '0 && cnt_q[rs2a_o] != '0;
    assign sat     = writes_rd && rd != '0 && cnt_q[rd] == '1;
    assign can     = bus.valid_i && (!valid_q || bus.ack_i) && !flush_i && !rst_i;
    assign accept  = can && !haz1 && !haz2 && !sat;
    assign stall_o = can && !accept;
    assign bus.ack_o = accept;

    // signed net change per register; a negative result is an over-release
    always_comb begin
        int t;
        t     = 0;
        cnt_d = '0;
        err_d = err_q;
        for (int r = 1; r < NREGS; r++) begin
            t = int'(cnt_q[r]) + int'(accept && writes_rd && rd == AW'(r))
                - int'(flush_i && valid_q && !bus.ack_i && rd_q == AW'(r));
            for (int k = 0; k < NUM_WB; k++)
                t = t - int'(wb_valid_i[k] && wb_rd_i[k*AW +: AW] == AW'(r));
            err_d    = err_d | (t < 0);
            cnt_d[r] = t < 0 ? '0 : CNT_W'(t);
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            cnt_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            rd_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (accept) begin
                valid_q <= 1'b1;
                instr_q <= bus.instr_i;
                pc_q    <= bus.pc_i;
                rs1_q   <= rs1d_i;
                rs2_q   <= rs2d_i;
                imm_q   <= XLEN'($signed(imm32));
                rd_q    <= writes_rd ? rd : '0;
            end else if (flush_i || bus.ack_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.instr_o = instr_q;
    assign bus.pc_o    = pc_q;
    assign bus.rs1_o   = rs1_q;
    assign bus.rs2_o   = rs2_q;
    assign bus.imm_o   = imm_q;
    assign bus.rd_o    = rd_q;
    assign sb_err_o    = err_q;

`ifdef ID_PERF_EN
    logic [31:0] perf_stall_q, perf_issue_q;
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            perf_stall_q <= '0;
            perf_issue_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_q + 32'(stall_o);
            perf_issue_q <= perf_issue_q + 32'(accept);
        end
    end
    assign perf_stall_o = perf_stall_q;
    assign perf_issue_o = perf_issue_q;
`endif
endmodule

// File: tb/tb_id_stage_sb.sv
// tb_id_stage_sb: directed scenarios plus randomized traffic against a counter-array model.
module tb_id_stage_sb;
    localparam logic [6:0] LUI = 7'h37, JAL = 7'h6f, OPI = 7'h13, OPR = 7'h33, BR = 7'h63, ST = 7'h23;
    logic        clk = 1'b0, rst_i = 1'b1, flush_i = 1'b0;
    logic [4:0]  rs1a_o, rs2a_o;
    logic [31:0] rs1d_i, rs2d_i;
    logic [1:0]  wb_valid_i;
    logic [9:0]  wb_rd_i;
    logic        stall_o, sb_err_o;
`ifdef ID_PERF_EN
    logic [31:0] perf_stall_o, perf_issue_o;
`endif
    id_stage_sb_if #(.XLEN(32), .AW(5)) bus ();

    id_stage_sb #(.XLEN(32), .NREGS(32), .CNT_W(2), .NUM_WB(2)) dut (
        .clk(clk), .rst_i(rst_i), .flush_i(flush_i), .bus(bus),
        .rs1a_o(rs1a_o), .rs2a_o(rs2a_o), .rs1d_i(rs1d_i), .rs2d_i(rs2d_i),
        .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .stall_o(stall_o), .sb_err_o(sb_err_o)
`ifdef ID_PERF_EN
        , .perf_stall_o(perf_stall_o), .perf_issue_o(perf_issue_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    int          m_cnt [32];
    bit          m_err, m_v;
    logic [31:0] m_instr, m_pc, m_rs1, m_rs2, m_imm;
    int          m_rd, m_nstall, m_nissue;
    bit          obs_ack, obs_stall, exp_ack, exp_stall;
    logic [4:0]  obs_r1a, obs_r2a;
    logic [31:0] cur_instr;
    logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h03, 7'h13, 7'h73, 7'h33, 7'h63, 7'h23, 7'h0b};

    // RISC-V operand usage and immediate, computed with signed arithmetic
    function automatic void dec(input logic [31:0] ins, output bit ur1, ur2, wrd, output logic [31:0] imm);
        int s, hi, t;
        s = ins;
        hi = s >>> 31;
        ur1 = 0; ur2 = 0; wrd = 0; imm = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin wrd = 1; imm = ins & 32'hffff_f000; end
            7'h6f: begin wrd = 1; imm = hi * 1048576 + ins[19:12] * 4096 + ins[20] * 2048 + ins[30:21] * 2; end
            7'h67, 7'h03, 7'h13, 7'h73: begin ur1 = 1; wrd = 1; t = s >>> 20; imm = t; end
            7'h33: begin ur1 = 1; ur2 = 1; wrd = 1; end
            7'h63: begin ur1 = 1; ur2 = 1; imm = hi * 4096 + ins[7] * 2048 + ins[30:25] * 32 + ins[11:8] * 2; end
            7'h23: begin ur1 = 1; ur2 = 1; t = s >>> 25; imm = t * 32 + ins[11:7]; end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input int rd, rs1, rs2);
        logic [31:0] w;
        w = $urandom;
        w[6:0] = op; w[11:7] = 5'(rd); w[19:15] = 5'(rs1); w[24:20] = 5'(rs2);
        return w;
    endfunction

    task automatic model_reset();
        foreach (m_cnt[r]) m_cnt[r] = 0;
        m_err = 0; m_v = 0; m_rd = 0; m_nstall = 0; m_nissue = 0;
        m_instr = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
    endtask

    task automatic idle();
        bus.valid_i = 0; bus.ack_i = 0; bus.instr_i = 0; bus.pc_i = 0; flush_i = 0;
        wb_valid_i = 0; wb_rd_i = 0; rs1d_i = $urandom; rs2d_i = $urandom;
    endtask

    // one clock: sample combinational outputs, predict, then advance the model
    task automatic tick();
        bit ur1, ur2, wrd, can;
        logic [31:0] imm;
        int rd, r1, r2, w;
        @(negedge clk);
        obs_ack = bus.ack_o; obs_stall = stall_o; obs_r1a = rs1a_o; obs_r2a = rs2a_o;
        cur_instr = bus.instr_i;
        dec(cur_instr, ur1, ur2, wrd, imm);
        rd = cur_instr[11:7]; r1 = cur_instr[19:15]; r2 = cur_instr[24:20];
        can = bus.valid_i && (!m_v || bus.ack_i) && !flush_i;
        exp_ack = can && !(ur1 && r1 != 0 && m_cnt[r1] != 0) && !(ur2 && r2 != 0 && m_cnt[r2] != 0)
                  && !(wrd && rd != 0 && m_cnt[rd] == 3);
        exp_stall = can && !exp_ack;
        @(posedge clk);
        if (flush_i && m_v && !bus.ack_i && m_rd != 0) m_cnt[m_rd]--;
        if (exp_ack) begin
            if (wrd && rd != 0) m_cnt[rd]++;
            m_instr = cur_instr; m_pc = bus.pc_i; m_rs1 = rs1d_i; m_rs2 = rs2d_i; m_imm = imm;
            m_rd = wrd ? rd : 0;
        end
        for (int k = 0; k < 2; k++) begin
            w = wb_rd_i[k*5 +: 5];
            if (wb_valid_i[k] && w != 0) m_cnt[w]--;
        end
        foreach (m_cnt[r]) if (m_cnt[r] < 0) begin m_cnt[r] = 0; m_err = 1; end
        m_v = exp_ack ? 1'b1 : (flush_i || bus.ack_i) ? 1'b0 : m_v;
        m_nstall += int'(exp_stall);
        m_nissue += int'(exp_ack);
        #1;
    endtask

    task automatic do_reset();
        idle(); rst_i = 1; @(posedge clk); #1; rst_i = 0; model_reset();
    endtask

    task automatic test_reset();
        idle(); rst_i = 1; bus.valid_i = 1; bus.instr_i = mk(OPI, 5, 1, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        if ({bus.valid_o, bus.ack_o, stall_o, sb_err_o} !== 4'b0) begin
            $display("FAIL reset_ctrl: got %b want 0000", {bus.valid_o, bus.ack_o, stall_o, sb_err_o}); n_err++;
        end
        n_vec++;
        if ({bus.instr_o, bus.pc_o, bus.rs1_o, bus.rs2_o, bus.imm_o, bus.rd_o} !== '0) begin
            $display("FAIL reset_pkt: got nonzero packet rd=%0d pc=%h", bus.rd_o, bus.pc_o); n_err++;
        end
        n_vec++;
        @(posedge clk); #1; rst_i = 0; model_reset();
        tick();
        if ({obs_ack, bus.valid_o, bus.rd_o} !== {1'b1, 1'b1, 5'd5}) begin
            $display("FAIL reset_issue: got ack/v/rd %b/%b/%0d want 1/1/5", obs_ack, bus.valid_o, bus.rd_o); n_err++;
        end
        n_vec++;
        bus.instr_i = mk(OPR, 6, 5, 1);
        #2 rst_i = 1;
        #1;
        if ({bus.valid_o, bus.ack_o, stall_o} !== 3'b0) begin
            $display("FAIL reset_async: got v/ack/stall %b want 000", {bus.valid_o, bus.ack_o, stall_o}); n_err++;
        end
        n_vec++;
        @(posedge clk); #1; rst_i = 0; model_reset();
        tick();
        if (obs_ack !== 1'b1) begin
            $display("FAIL reset_cnt_clear: got ack %b want 1", obs_ack); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_raw();
        do_reset();
        bus.ack_i = 1; bus.valid_i = 1; bus.instr_i = mk(OPI, 5, 1, 0);
        tick();
        if (obs_ack !== 1'b1) begin $display("FAIL raw_issue: got ack %b want 1", obs_ack); n_err++; end
        n_vec++;
        bus.instr_i = mk(OPR, 6, 5, 1); rs1d_i = $urandom; rs2d_i = $urandom;
        tick();
        if ({obs_stall, obs_ack} !== 2'b10) begin
            $display("FAIL raw_stall: got stall/ack %b want 10", {obs_stall, obs_ack}); n_err++;
        end
        n_vec++;
        wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd5};
        tick();
        if (obs_ack !== 1'b0) begin $display("FAIL raw_wb_cycle: got ack %b want 0", obs_ack); n_err++; end
        n_vec++;
        wb_valid_i = 0;
        tick();
        if (obs_ack !== 1'b1) begin $display("FAIL raw_release: got ack %b want 1", obs_ack); n_err++; end
        n_vec++;
        if ({bus.rd_o, bus.rs1_o, bus.rs2_o} !== {5'd6, m_rs1, m_rs2}) begin
            $display("FAIL raw_pkt: got rd=%0d rs1=%h rs2=%h want rd=6 rs1=%h rs2=%h", bus.rd_o, bus.rs1_o, bus.rs2_o, m_rs1, m_rs2); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_waw();
        do_reset();
        bus.ack_i = 1; bus.valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            bus.instr_i = mk(OPI, 7, 0, 0);
            tick();
            if (obs_ack !== 1'b1) begin $display("FAIL waw_issue%0d: got ack %b want 1", i, obs_ack); n_err++; end
            n_vec++;
        end
        bus.instr_i = mk(LUI, 7, 0, 0);
        tick();
        if (obs_stall !== 1'b1) begin $display("FAIL waw_sat: got stall %b want 1", obs_stall); n_err++; end
        n_vec++;
        wb_valid_i = 2'b10; wb_rd_i = {5'd7, 5'd0};
        tick();
        if (obs_stall !== 1'b1) begin $display("FAIL waw_wb_cycle: got stall %b want 1", obs_stall); n_err++; end
        n_vec++;
        wb_valid_i = 0;
        tick();
        if ({obs_ack, bus.rd_o} !== {1'b1, 5'd7}) begin
            $display("FAIL waw_release: got ack/rd %b/%0d want 1/7", obs_ack, bus.rd_o); n_err++;
        end
        n_vec++;
    endtask

    task automatic test_dual_release();
        do_reset();
        bus.ack_i = 1; bus.valid_i = 1; bus.instr_i = mk(OPI, 9, 0, 0);
        repeat (2) tick();
        bus.valid_i = 0; wb_valid_i = 2'b11; wb_rd_i = {5'd9, 5'd9};
        tick();
        if (sb_err_o !== 1'b0) begin $display("FAIL dual_no_err: got err %b want 0", sb_err_o); n_err++; end
        n_vec++;
        wb_valid_i = 0; bus.valid_i = 1; bus.instr_i = mk(OPR, 10, 9, 9);
        tick();
        if (obs_ack !== 1'b1) begin $display("FAIL dual_cleared: got ack %b want 1", obs_ack); n_err++; end
        n_vec++;
        bus.valid_i = 0; wb_valid_i = 2'b01; wb_rd_i = {5'd0, 5'd9};
        tick();
        if (sb_err_o !== 1'b1) begin $display("FAIL dual_underflow: got err %b want 1", sb_err_o); n_err++; end
        n_vec++;
        wb_valid_i = 0;
        repeat (2) tick();
        if (sb_err_o !== 1'b1) begin $display("FAIL err_sticky: got err %b want 1", sb_err_o); n_err++; end
        n_vec++;
    endtask

    task automatic test_flush();
        do_reset();
        bus.valid_i = 1; bus.instr_i = mk(LUI, 3, 0, 0);
        tick();
        if ({bus.valid_o, bus.rd_o} !== {1'b1, 5'd3}) begin
            $display("FAIL flush_setup: got v/rd %b/%0d want 1/3", bus.valid_o, bus.rd_o); n_err++;
        end
        n_vec++;
        bus.instr_i = mk(OPR, 4, 3, 3); flush_i = 1;
        tick();
        if ({obs_ack, obs_stall, bus.valid_o} !== 3'b000) begin
            $display("FAIL flush_kill: got ack/stall/v %b want 000", {obs_ack, obs_stall, bus.valid_o}); n_err++;
        end
        n_vec++;
        flush_i = 0;
        tick();
        if (obs_ack !== 1'b1) begin $display("FAIL flush_lock_returned: got ack %b want 1", obs_ack); n_err++; end
        n_vec++;
    endtask

    task automatic test_store_branch();
        do_reset();
        bus.ack_i = 1; bus.valid_i = 1; bus.instr_i = mk(ST, 5, 4, 2);
        tick();
        if ({obs_ack, bus.rd_o, bus.imm_o} !== {1'b1, 5'd0, m_imm}) begin
            $display("FAIL store: got ack/rd/imm %b/%0d/%h want 1/0/%h", obs_ack, bus.rd_o, bus.imm_o, m_imm); n_err++;
        end
        n_vec++;
        bus.instr_i = mk(OPI, 6, 5, 0);
        tick();
        if (obs_ack !== 1'b1) begin $display("FAIL store_no_lock: got ack %b want 1", obs_ack); n_err++; end
        n_vec++;
        bus.instr_i = mk(LUI, 0, 0, 0);
        tick();
        bus.instr_i = mk(BR, 12, 0, 0);
        tick();
        if ({obs_ack, bus.imm_o} !== {1'b1, m_imm}) begin
            $display("FAIL beq_x0: got ack/imm %b/%h want 1/%h", obs_ack, bus.imm_o, m_imm); n_err++;
        end
        n_vec++;
        bus.instr_i = mk(JAL, 1, 0, 0);
        tick();
        if (bus.imm_o !== m_imm) begin $display("FAIL jal_imm: got %h want %h", bus.imm_o, m_imm); n_err++; end
        n_vec++;
    endtask

    task automatic test_random(input int n);
        int r, pend;
        do_reset();
        for (int i = 0; i < n; i++) begin
            bus.valid_i = $urandom_range(0, 9) < 7;
            bus.instr_i = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            bus.pc_i = $urandom; rs1d_i = $urandom; rs2d_i = $urandom;
            bus.ack_i = $urandom_range(0, 9) < 6;
            flush_i = $urandom_range(0, 19) == 0;
            wb_valid_i = 0; wb_rd_i = 0;
            for (int k = 0; k < 2; k++) begin
                r = $urandom_range(1, 7);
                pend = (k == 1 && wb_valid_i[0] && int'(wb_rd_i[4:0]) == r) ? 1 : 0;
                if ($urandom_range(0, 9) < 4 && m_cnt[r] > pend) begin
                    wb_valid_i[k] = 1'b1; wb_rd_i[k*5 +: 5] = 5'(r);
                end
            end
            tick();
            if ({obs_ack, obs_stall, obs_r1a, obs_r2a} !== {exp_ack, exp_stall, cur_instr[19:15], cur_instr[24:20]}) begin
                $display("FAIL rnd_comb cyc %0d: got ack/stall/ra %b/%b/%0d,%0d want %b/%b/%0d,%0d", i, obs_ack, obs_stall,
                         obs_r1a, obs_r2a, exp_ack, exp_stall, cur_instr[19:15], cur_instr[24:20]); n_err++;
            end
            n_vec++;
            if ({bus.valid_o, sb_err_o} !== {m_v, m_err}) begin
                $display("FAIL rnd_state cyc %0d: got v/err %b/%b want %b/%b", i, bus.valid_o, sb_err_o, m_v, m_err); n_err++;
            end
            n_vec++;
            if (m_v && {bus.instr_o, bus.pc_o, bus.rs1_o, bus.rs2_o, bus.imm_o, bus.rd_o} !==
                       {m_instr, m_pc, m_rs1, m_rs2, m_imm, 5'(m_rd)}) begin
                $display("FAIL rnd_pkt cyc %0d: got %h %h %h %h %h %0d want %h %h %h %h %h %0d", i, bus.instr_o, bus.pc_o,
                         bus.rs1_o, bus.rs2_o, bus.imm_o, bus.rd_o, m_instr, m_pc, m_rs1, m_rs2, m_imm, m_rd); n_err++;
            end
            n_vec++;
        end
`ifdef ID_PERF_EN
        if ({perf_stall_o, perf_issue_o} !== {32'(m_nstall), 32'(m_nissue)}) begin
            $display("FAIL perf: got stall/issue %0d/%0d want %0d/%0d", perf_stall_o, perf_issue_o, m_nstall, m_nissue); n_err++;
        end
        n_vec++;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        model_reset();
        test_reset();
        test_raw();
        test_waw();
        test_dual_release();
        test_flush();
        test_store_branch();
        test_random(400);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
